// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back logic for the RV32I 5-stage pipeline.
// Captures MEM-stage results, aligns and extends load data, selects the
// write-back value and drives the register-file write port.
// Optional feature: define WB_INSTRET_EN to add the retired-instruction
// counter (InstRetW, CNT_W bits wide).
module wb_stage #(
  parameter int unsigned XLEN = 32
`ifdef WB_INSTRET_EN
  , parameter int unsigned CNT_W = 64
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_w,
  input  logic            flush_w,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [2:0]      WriteBackM,
  input  logic [2:0]      funct3M,
  input  logic [4:0]      RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ImmExtM,
  input  logic [XLEN-1:0] PCTargetM,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [XLEN-1:0] ResultW,
  output logic            ValidW
`ifdef WB_INSTRET_EN
  , output logic [CNT_W-1:0] InstRetW
`endif
);

  logic            valid_q;
  logic            reg_write_q;
  logic [2:0]      wb_sel_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] read_data_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic [XLEN-1:0] imm_ext_q;
  logic [XLEN-1:0] pc_target_q;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] load_data;

  // MEM/WB register: reset > flush > stall > load
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      wb_sel_q     <= 3'b000;
      funct3_q     <= 3'b000;
      rd_q         <= 5'd0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      pc_plus4_q   <= '0;
      imm_ext_q    <= '0;
      pc_target_q  <= '0;
    end else if (flush_w) begin
      // Bubble: only the control bits matter, data fields simply hold
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall_w) begin
      valid_q      <= ValidM;
      reg_write_q  <= RegWriteM;
      wb_sel_q     <= WriteBackM;
      funct3_q     <= funct3M;
      rd_q         <= RdM;
      alu_result_q <= ALUResultM;
      read_data_q  <= ReadDataM;
      pc_plus4_q   <= PCPlus4M;
      imm_ext_q    <= ImmExtM;
      pc_target_q  <= PCTargetM;
    end
  end

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q;

  // Retired-instruction counter; counts valid loads into WB, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (!flush_w && !stall_w && ValidM) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign InstRetW = instret_q;
`endif

  // Load alignment: byte lane from the full offset, half lane from offset bit 1 only
  always_comb begin
    ld_byte = read_data_q[{alu_result_q[1:0], 3'b000} +: 8];
    ld_half = read_data_q[{alu_result_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data = read_data_q;
    endcase
  end

  // Write-back select, driven from registered fields only
  always_comb begin
    case (wb_sel_q)
      3'b001:  ResultW = load_data;
      3'b010:  ResultW = pc_plus4_q;
      3'b011:  ResultW = imm_ext_q;
      3'b100:  ResultW = pc_target_q;
      default: ResultW = alu_result_q;
    endcase
  end

  assign ValidW    = valid_q;
  assign RdW       = rd_q;
  // x0 is never written
  assign RegWriteW = reg_write_q & valid_q & (rd_q != 5'd0);

endmodule
